mem_arbiter: RTL and testbench

- Shares the single byte-serial memory controller between two requesters: port I (instruction fetch) and port D (data load/store).
- Accepts level-held requests and issues one controller operation at a time, using a one-cycle start pulse.
- Waits for the controller's done pulse, then returns read data plus a one-cycle ack to the winning requester.
- Sits between the CPU core's fetch/execute stages and the memory controller; provides round-robin fairness and a watchdog timeout.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single byte-serial memory controller.
// Port I fetches words, port D loads/stores; a watchdog aborts operations that never complete.
module mem_arbiter #(
  parameter int TIMEOUT = 32,
  parameter bit D_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_read_data,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic [2:0]  d_mode,
  input  logic        d_write_enable,
  input  logic [31:0] d_write_data,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_read_data,
  output logic        mc_start,
  output logic [31:0] mc_address,
  output logic [2:0]  mc_mode,
  output logic        mc_write_enable,
  output logic [31:0] mc_write_data,
  input  logic        mc_done,
  input  logic [31:0] mc_read_data,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic       PORT_I   = 1'b0;
  localparam logic       PORT_D   = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] MODE_LW  = 3'b010;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic [31:0] i_read_data_q, i_read_data_d;
  logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] d_read_data_q, d_read_data_d;
  logic        mc_start_q, mc_start_d;
  logic [31:0] mc_address_q, mc_address_d;
  logic [2:0]  mc_mode_q, mc_mode_d;
  logic        mc_write_enable_q, mc_write_enable_d;
  logic [31:0] mc_write_data_q, mc_write_data_d;
  logic        busy_q, busy_d;
  logic        grant_d;
  logic        d_illegal;

  // Reserved FUNC3 encodings, plus unsigned stores and LWU-style loads.
  assign d_illegal = (d_mode[1:0] == 2'b11) ||
                     ((d_mode == 3'b110) && !d_write_enable) ||
                     (d_mode[2] && d_write_enable);

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_grant_d      = last_grant_q;
    cnt_d             = cnt_q;
    grant_d           = PORT_I;
    i_err_d           = i_err_q;
    i_read_data_d     = i_read_data_q;
    d_err_d           = d_err_q;
    d_read_data_d     = d_read_data_q;
    mc_address_d      = mc_address_q;
    mc_mode_d         = mc_mode_q;
    mc_write_enable_d = mc_write_enable_q;
    mc_write_data_d   = mc_write_data_q;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d      = d_req && (!i_req || (last_grant_q == PORT_I));
          owner_d      = grant_d;
          last_grant_d = grant_d;
          if (grant_d == PORT_D) begin
            if (d_illegal) begin
              d_err_d       = 1'b1;
              d_read_data_d = 32'h0;
              state_d       = S_RESP;
            end else begin
              mc_address_d      = d_address;
              mc_mode_d         = d_mode;
              mc_write_enable_d = d_write_enable;
              mc_write_data_d   = d_write_data;
              state_d           = S_ISSUE;
            end
          end else begin
            mc_address_d      = i_address;
            mc_mode_d         = MODE_LW;
            mc_write_enable_d = 1'b0;
            mc_write_data_d   = 32'h0;
            state_d           = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mc_done) begin
          if (owner_q == PORT_D) begin
            d_read_data_d = mc_read_data;
            d_err_d       = 1'b0;
          end else begin
            i_read_data_d = mc_read_data;
            i_err_d       = 1'b0;
          end
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          if (owner_q == PORT_D) begin
            d_read_data_d = 32'h0;
            d_err_d       = 1'b1;
          end else begin
            i_read_data_d = 32'h0;
            i_err_d       = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    mc_start_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
    i_ack_d    = (state_d == S_RESP) && (owner_d == PORT_I);
    d_ack_d    = (state_d == S_RESP) && (owner_d == PORT_D);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      owner_q           <= PORT_I;
      last_grant_q      <= D_FIRST ? PORT_I : PORT_D;
      cnt_q             <= 8'd0;
      i_ack_q           <= 1'b0;
      i_err_q           <= 1'b0;
      i_read_data_q     <= 32'h0;
      d_ack_q           <= 1'b0;
      d_err_q           <= 1'b0;
      d_read_data_q     <= 32'h0;
      mc_start_q        <= 1'b0;
      mc_address_q      <= 32'h0;
      mc_mode_q         <= 3'b000;
      mc_write_enable_q <= 1'b0;
      mc_write_data_q   <= 32'h0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      last_grant_q      <= last_grant_d;
      cnt_q             <= cnt_d;
      i_ack_q           <= i_ack_d;
      i_err_q           <= i_err_d;
      i_read_data_q     <= i_read_data_d;
      d_ack_q           <= d_ack_d;
      d_err_q           <= d_err_d;
      d_read_data_q     <= d_read_data_d;
      mc_start_q        <= mc_start_d;
      mc_address_q      <= mc_address_d;
      mc_mode_q         <= mc_mode_d;
      mc_write_enable_q <= mc_write_enable_d;
      mc_write_data_q   <= mc_write_data_d;
      busy_q            <= busy_d;
    end
  end

  assign i_ack           = i_ack_q;
  assign i_err           = i_err_q;
  assign i_read_data     = i_read_data_q;
  assign d_ack           = d_ack_q;
  assign d_err           = d_err_q;
  assign d_read_data     = d_read_data_q;
  assign mc_start        = mc_start_q;
  assign mc_address      = mc_address_q;
  assign mc_mode         = mc_mode_q;
  assign mc_write_enable = mc_write_enable_q;
  assign mc_write_data   = mc_write_data_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single-port transactions against a behavioural
// controller model, plus hand-written timeout, reset-in-WAIT and contention sequences.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_address = 32'h0;
  logic        i_ack, i_err;
  logic [31:0] i_read_data;
  logic        d_req = 1'b0;
  logic [31:0] d_address = 32'h0;
  logic [2:0]  d_mode = 3'b000;
  logic        d_write_enable = 1'b0;
  logic [31:0] d_write_data = 32'h0;
  logic        d_ack, d_err;
  logic [31:0] d_read_data;
  logic        mc_start;
  logic [31:0] mc_address;
  logic [2:0]  mc_mode;
  logic        mc_write_enable;
  logic [31:0] mc_write_data;
  logic        mc_done = 1'b0;
  logic [31:0] mc_read_data = 32'h0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(8), .D_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_err(i_err), .i_read_data(i_read_data),
    .d_req(d_req), .d_address(d_address), .d_mode(d_mode), .d_write_enable(d_write_enable),
    .d_write_data(d_write_data), .d_ack(d_ack), .d_err(d_err), .d_read_data(d_read_data),
    .mc_start(mc_start), .mc_address(mc_address), .mc_mode(mc_mode),
    .mc_write_enable(mc_write_enable), .mc_write_data(mc_write_data),
    .mc_done(mc_done), .mc_read_data(mc_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Controller model: no reset, pulses done mc_lat cycles after seeing start.
  int          mc_lat = 2;
  logic [31:0] mc_rsp = 32'h0;
  bit          mc_en = 1'b1;
  bit          mc_busy = 1'b0;
  int          mc_cnt = 0;
  always @(posedge clk) begin
    mc_done <= 1'b0;
    if (mc_start && mc_en) begin
      mc_busy <= 1'b1;
      mc_cnt  <= mc_lat;
    end else if (mc_busy) begin
      if (mc_cnt <= 1) begin
        mc_done      <= 1'b1;
        mc_read_data <= mc_rsp;
        mc_busy      <= 1'b0;
      end else begin
        mc_cnt <= mc_cnt - 1;
      end
    end
  end

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [2:0]  mode;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_starts;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    logic [2:0]  exp_mode;
    logic        exp_we;
    logic [31:0] exp_wdata;
    int          starts, done_at, ack_at, exp_at;
    bit          wrong_ack, hold_bad, got_err;
    logic [31:0] got_rd;
    exp_mode  = v.is_d ? v.mode : 3'b010;
    exp_we    = v.is_d ? v.we : 1'b0;
    exp_wdata = v.is_d ? v.wdata : 32'h0;
    starts = 0; done_at = -1; ack_at = -1;
    wrong_ack = 1'b0; hold_bad = 1'b0; got_err = 1'b0; got_rd = 32'h0;
    @(negedge clk);
    mc_lat = v.lat; mc_rsp = v.rsp; mc_en = 1'b1;
    if (v.is_d) begin
      d_req = 1'b1; d_address = v.addr; d_mode = v.mode;
      d_write_enable = v.we; d_write_data = v.wdata;
    end else begin
      i_req = 1'b1; i_address = v.addr;
    end
    for (int c = 1; c <= 40 && ack_at < 0; c++) begin
      @(negedge clk);
      if (mc_start) starts++;
      if (starts > 0) begin
        if (mc_address !== v.addr || mc_mode !== exp_mode ||
            mc_write_enable !== exp_we || mc_write_data !== exp_wdata) hold_bad = 1'b1;
        i_address = 32'hBAD0_0000; d_address = 32'hBAD0_0000; d_write_data = 32'h1234_5678;
      end
      if (mc_done && done_at < 0) done_at = c;
      if (v.is_d ? i_ack : d_ack) wrong_ack = 1'b1;
      if (v.is_d ? d_ack : i_ack) begin
        ack_at  = c;
        got_err = v.is_d ? d_err : i_err;
        got_rd  = v.is_d ? d_read_data : i_read_data;
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    exp_at = (v.exp_starts == 0) ? 1 : done_at + 1;
    chk({tag, "_ack_seen"}, ack_at >= 0, 1'b1);
    chk({tag, "_err"}, got_err, v.exp_err);
    chk({tag, "_rdata"}, got_rd, v.exp_rdata);
    chk({tag, "_starts"}, starts, v.exp_starts);
    chk({tag, "_other_ack"}, wrong_ack, 1'b0);
    chk({tag, "_mc_hold"}, hold_bad, 1'b0);
    chk({tag, "_ack_cycle"}, ack_at, exp_at);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, v.is_d ? d_ack : i_ack, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int          start_c, ack_c, n, last_ack_c;
    bit          stray, seen, t_err;
    logic [31:0] t_rd;
    logic [31:0] order[4];
    logic [31:0] exp_order[4];

    //            is_d  addr          mode    we    wdata          rsp            lat err   exp_rdata      starts
    vecs[0] = '{1'b1, 32'h0000_0100, 3'b000, 1'b0, 32'h0,         32'hFFFF_FF80, 2, 1'b0, 32'hFFFF_FF80, 1};
    vecs[1] = '{1'b1, 32'h0000_0020, 3'b010, 1'b1, 32'hDEAD_BEEF, 32'h0,         3, 1'b0, 32'h0,         1};
    vecs[2] = '{1'b0, 32'h0000_0000, 3'b000, 1'b0, 32'h0,         32'h0000_0013, 1, 1'b0, 32'h0000_0013, 1};
    vecs[3] = '{1'b1, 32'h0000_0040, 3'b011, 1'b0, 32'h0,         32'h5A5A_5A5A, 2, 1'b1, 32'h0,         0};
    vecs[4] = '{1'b1, 32'h0000_0041, 3'b100, 1'b0, 32'h0,         32'h0000_00AB, 4, 1'b0, 32'h0000_00AB, 1};
    vecs[5] = '{1'b0, 32'h0000_0400, 3'b000, 1'b0, 32'h0,         32'hCAFE_F00D, 5, 1'b0, 32'hCAFE_F00D, 1};
    vecs[6] = '{1'b1, 32'h0000_0044, 3'b110, 1'b0, 32'h0,         32'h1111_1111, 2, 1'b1, 32'h0,         0};
    vecs[7] = '{1'b1, 32'h0000_0048, 3'b100, 1'b1, 32'h0000_0077, 32'h2222_2222, 2, 1'b1, 32'h0,         0};

    apply_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_mc_start", mc_start, 1'b0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 4'h0);
    chk("rst_i_rdata", i_read_data, 32'h0);
    chk("rst_d_rdata", d_read_data, 32'h0);
    chk("rst_mc_addr", mc_address, 32'h0);
    chk("rst_mc_ctl", {mc_mode, mc_write_enable}, 4'h0);
    chk("rst_mc_wdata", mc_write_data, 32'h0);

    for (int k = 0; k < 8; k++) do_txn(vecs[k], $sformatf("vec%0d", k));

    // Watchdog: done arrives only after the abort and must be ignored.
    @(negedge clk);
    mc_lat = 12; mc_rsp = 32'h9999_9999; mc_en = 1'b1;
    i_req = 1'b1; i_address = 32'h80;
    start_c = -1; ack_c = -1; t_err = 1'b0; t_rd = 32'hFFFF_FFFF;
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(negedge clk);
      if (mc_start) start_c = c;
      if (i_ack) begin
        ack_c = c; t_err = i_err; t_rd = i_read_data; i_req = 1'b0;
      end
    end
    chk("tmo_ack_delay", ack_c - start_c, 9);
    chk("tmo_err", t_err, 1'b1);
    chk("tmo_rdata", t_rd, 32'h0);
    stray = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (i_ack || d_ack || busy) stray = 1'b1;
    end
    chk("tmo_late_done_ignored", stray, 1'b0);
    chk("tmo_err_held", i_err, 1'b1);
    chk("tmo_rdata_held", i_read_data, 32'h0);

    // Reset while waiting on the controller.
    @(negedge clk);
    mc_lat = 6; mc_rsp = 32'h0000_0077;
    d_req = 1'b1; d_address = 32'h300; d_mode = 3'b000; d_write_enable = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mc_start) seen = 1'b1;
    end
    chk("rstw_start_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    chk("rstw_busy_before", busy, 1'b1);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_busy_after", busy, 1'b0);
    chk("rstw_no_ack", {i_ack, d_ack, i_err, d_err}, 4'h0);
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (i_ack || d_ack || busy) stray = 1'b1;
    end
    chk("rstw_stray_done_ignored", stray, 1'b0);
    do_txn('{1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 32'h1122_3344, 2, 1'b0, 32'h1122_3344, 1}, "rstw_fetch");

    // Contention from reset with both requests held: D, I, D, I.
    apply_reset();
    mc_lat = 2; mc_rsp = 32'h5555_0000; mc_en = 1'b1;
    d_req = 1'b1; d_address = 32'h200; d_mode = 3'b010; d_write_enable = 1'b0;
    i_req = 1'b1; i_address = 32'h300;
    exp_order[0] = 32'hD; exp_order[1] = 32'h1; exp_order[2] = 32'hD; exp_order[3] = 32'h1;
    for (int k = 0; k < 4; k++) order[k] = 32'h0;
    n = 0; last_ack_c = -1;
    for (int c = 1; c <= 200 && n < 4; c++) begin
      @(negedge clk);
      if (mc_start) begin
        chk($sformatf("cont_addr%0d", n), mc_address, (exp_order[n] == 32'hD) ? 32'h200 : 32'h300);
        if (last_ack_c > 0) chk($sformatf("cont_gap%0d", n), c - last_ack_c, 2);
      end
      if (d_ack || i_ack) begin
        order[n] = d_ack ? 32'hD : 32'h1;
        last_ack_c = c;
        n++;
        if (n == 4) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("cont_order%0d", k), order[k], exp_order[k]);
    @(negedge clk);
    chk("cont_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
